// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register: FSM encoding,
// default reset/bubble values and the entry header packing helper.
package pipe_pkg;

  // Occupancy-coded states: the encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEF_RST_PC    = 32'h0000_3008;

  // Header part of an entry vector; payload lanes and side-band follow below it.
  function automatic logic [63:0] packHdr(input logic [31:0] instr, input logic [31:0] pc);
    return {instr, pc};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bus carrying one pipeline entry (instruction, pc+, payload, side-band).
interface pipe_stage_reg_if #(
  parameter int NLANES = 3,
  parameter int LANE_W = 32,
  parameter int AUX_W  = 2
);
  logic                     valid;
  logic                     ready;
  logic [31:0]              instr;
  logic [31:0]              pc;
  logic [NLANES*LANE_W-1:0] data;
  logic [AUX_W-1:0]         aux;

  modport master (output valid, instr, pc, data, aux, input ready);
  modport slave  (input valid, instr, pc, data, aux, output ready);
endinterface

// File: rtl/pipe_slot.sv
// Single entry register: loads d when en is high, async reset to RST_VAL.
module pipe_slot #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Enable-loaded storage; reset value is fixed per instance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// one extra skid entry for stalls, flush-to-bubble and a saturating stall counter.
// All downstream outputs come straight from registers.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          NLANES    = 3,
  parameter int          LANE_W    = 32,
  parameter int          AUX_W     = 2,
  parameter logic [31:0] RST_PC    = DEF_RST_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_reg_if.slave   inBus,
  pipe_stage_reg_if.master  outBus,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int DATA_W    = NLANES * LANE_W;
  localparam int TAIL_W    = 32 + DATA_W + AUX_W;   // everything below the instruction
  localparam int ENTRY_W   = 32 + TAIL_W;
  localparam logic [ENTRY_W-1:0] MAIN_RST = {NOP_INSTR, RST_PC, {(DATA_W + AUX_W){1'b0}}};

  state_t             stateReg;
  state_t             stateNext;
  logic               inReadyInt;
  logic               outValidInt;
  logic               inFire;
  logic               outFire;
  logic               loadMain;
  logic               loadSkid;
  logic               fromSkid;
  logic               bubble;
  logic               mainEn;
  logic [ENTRY_W-1:0] inEntry;
  logic [ENTRY_W-1:0] mainD;
  logic [ENTRY_W-1:0] mainQ;
  logic [ENTRY_W-1:0] skidQ;
  logic [CNT_W-1:0]   stallReg;

  assign inReadyInt  = (stateReg != SKID) & ~flush & ~rst;
  assign outValidInt = (stateReg != EMPTY);
  assign inFire      = inBus.valid & inReadyInt;
  assign outFire     = outValidInt & outBus.ready;

  assign inEntry = {packHdr(inBus.instr, inBus.pc), inBus.data, inBus.aux};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= EMPTY;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next state and slot load controls; flush overrides every transition.
  always_comb begin
    stateNext = stateReg;
    loadMain  = 1'b0;
    loadSkid  = 1'b0;
    fromSkid  = 1'b0;
    bubble    = 1'b0;
    if (flush) begin
      stateNext = EMPTY;
      bubble    = 1'b1;
    end else begin
      case (stateReg)
        EMPTY: begin
          if (inFire) begin
            loadMain  = 1'b1;
            stateNext = FULL;
          end
        end
        FULL: begin
          if (inFire && outFire) begin
            loadMain = 1'b1;
          end else if (inFire) begin
            loadSkid  = 1'b1;
            stateNext = SKID;
          end else if (outFire) begin
            bubble    = 1'b1;
            stateNext = EMPTY;
          end
        end
        SKID: begin
          if (outFire) begin
            fromSkid  = 1'b1;
            stateNext = FULL;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  // A bubble rewrites only the instruction so downstream decodes a NOP;
  // pc, payload and side-band keep their last values.
  assign mainEn = loadMain | fromSkid | bubble;
  assign mainD  = fromSkid ? skidQ :
                  loadMain ? inEntry :
                  {NOP_INSTR, mainQ[TAIL_W-1:0]};

  pipe_slot #(.W(ENTRY_W), .RST_VAL(MAIN_RST)) mainSlot (
    .clk (clk),
    .rst (rst),
    .en  (mainEn),
    .d   (mainD),
    .q   (mainQ)
  );

  pipe_slot #(.W(ENTRY_W), .RST_VAL('0)) skidSlot (
    .clk (clk),
    .rst (rst),
    .en  (loadSkid),
    .d   (inEntry),
    .q   (skidQ)
  );

  // Count cycles where an entry is offered but not taken; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallReg <= '0;
    end else if (outValidInt && !outBus.ready && (stallReg != {CNT_W{1'b1}})) begin
      stallReg <= stallReg + 1'b1;
    end
  end

  assign inBus.ready  = inReadyInt;
  assign outBus.valid = outValidInt;
  assign outBus.instr = mainQ[ENTRY_W-1 -: 32];
  assign outBus.pc    = mainQ[TAIL_W-1 -: 32];
  assign outBus.data  = mainQ[AUX_W +: DATA_W];
  assign outBus.aux   = mainQ[AUX_W-1:0];
  assign occupancy    = stateReg;   // encoding equals the entry count
  assign stall_cnt    = stallReg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed handshake/flush/reset checks on a default
// instance, counter saturation and a randomized traffic run on a narrow instance
// checked against a queue-based model.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst;
  logic flushA;
  logic flushB;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.NLANES(3), .LANE_W(32), .AUX_W(2)) aUp ();
  pipe_stage_reg_if #(.NLANES(3), .LANE_W(32), .AUX_W(2)) aDn ();
  pipe_stage_reg_if #(.NLANES(1), .LANE_W(32), .AUX_W(5)) bUp ();
  pipe_stage_reg_if #(.NLANES(1), .LANE_W(32), .AUX_W(5)) bDn ();

  logic [1:0]  aOcc;
  logic [1:0]  bOcc;
  logic [15:0] aStall;
  logic [3:0]  bStall;

  pipe_stage_reg #(.NLANES(3), .LANE_W(32), .AUX_W(2), .CNT_W(16)) dutA (
    .clk       (clk),
    .rst       (rst),
    .flush     (flushA),
    .inBus     (aUp),
    .outBus    (aDn),
    .occupancy (aOcc),
    .stall_cnt (aStall)
  );

  pipe_stage_reg #(.NLANES(1), .LANE_W(32), .AUX_W(5), .CNT_W(4)) dutB (
    .clk       (clk),
    .rst       (rst),
    .flush     (flushB),
    .inBus     (bUp),
    .outBus    (bDn),
    .occupancy (bOcc),
    .stall_cnt (bStall)
  );

  int numTests = 0;
  int numFail  = 0;

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    numTests++;
    if (got !== exp) begin
      numFail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offerA(input logic [31:0] instr, input logic [31:0] pc);
    aUp.valid = 1'b1;
    aUp.instr = instr;
    aUp.pc    = pc;
    aUp.data  = {$urandom, $urandom, $urandom};
    aUp.aux   = 2'($urandom);
  endtask

  // Reference model for the narrow instance: a FIFO of at most two entries.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  aux;
  } ent_t;

  ent_t        mq[$];
  ent_t        lastHead;
  ent_t        head;
  ent_t        newEnt;
  int unsigned mStall;
  bit          expValid;
  bit          expReady;
  bit          mInFire;
  bit          mOutFire;
  bit          mStallInc;
  bit          mFlush;

  logic [31:0] si [3];
  logic [95:0] sd [3];

  initial begin
    si[0] = 32'h8C01_0004;
    si[1] = 32'h0022_1820;
    si[2] = 32'hAC03_0008;
    rst = 1'b1;
    flushA = 1'b0;
    flushB = 1'b0;
    aUp.valid = 1'b0; aUp.instr = '0; aUp.pc = '0; aUp.data = '0; aUp.aux = '0;
    aDn.ready = 1'b0;
    bUp.valid = 1'b0; bUp.instr = '0; bUp.pc = '0; bUp.data = '0; bUp.aux = '0;
    bDn.ready = 1'b0;

    // Reset state.
    tick();
    tick();
    checkVal("rst_valid", 128'(aDn.valid), 128'(0));
    checkVal("rst_instr", 128'(aDn.instr), 128'(32'h0));
    checkVal("rst_pc", 128'(aDn.pc), 128'(32'h0000_3008));
    checkVal("rst_data", 128'(aDn.data), 128'(0));
    checkVal("rst_occ", 128'(aOcc), 128'(0));
    checkVal("rst_stall", 128'(aStall), 128'(0));
    checkVal("rst_in_ready", 128'(aUp.ready), 128'(0));
    rst = 1'b0;
    #1;
    checkVal("rel_in_ready", 128'(aUp.ready), 128'(1));

    // Streaming: each entry appears one cycle after acceptance.
    aDn.ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sd[k] = {$urandom, $urandom, $urandom};
      aUp.valid = 1'b1;
      aUp.instr = si[k];
      aUp.pc    = 32'h400 + 32'(4 * k);
      aUp.data  = sd[k];
      aUp.aux   = 2'(k);
      tick();
      checkVal("stream_valid", 128'(aDn.valid), 128'(1));
      checkVal("stream_instr", 128'(aDn.instr), 128'(si[k]));
      checkVal("stream_pc", 128'(aDn.pc), 128'(32'h400 + 32'(4 * k)));
      checkVal("stream_data", 128'(aDn.data), 128'(sd[k]));
      checkVal("stream_aux", 128'(aDn.aux), 128'(k));
      checkVal("stream_occ", 128'(aOcc), 128'(1));
    end
    aUp.valid = 1'b0;
    tick();
    checkVal("drain_valid", 128'(aDn.valid), 128'(0));
    checkVal("drain_instr", 128'(aDn.instr), 128'(0));
    checkVal("drain_pc_hold", 128'(aDn.pc), 128'(32'h408));
    checkVal("stream_stall", 128'(aStall), 128'(0));

    // Stall into the skid entry, then drain in order.
    aDn.ready = 1'b0;
    offerA(si[0], 32'h500);
    tick();
    checkVal("stall1_instr", 128'(aDn.instr), 128'(si[0]));
    checkVal("stall1_occ", 128'(aOcc), 128'(1));
    offerA(si[1], 32'h504);
    tick();
    aUp.valid = 1'b0;
    checkVal("skid_occ", 128'(aOcc), 128'(2));
    checkVal("skid_in_ready", 128'(aUp.ready), 128'(0));
    checkVal("skid_head", 128'(aDn.instr), 128'(si[0]));
    tick();
    tick();
    checkVal("stall_cnt3", 128'(aStall), 128'(3));
    aDn.ready = 1'b1;
    tick();
    checkVal("unskid_instr", 128'(aDn.instr), 128'(si[1]));
    checkVal("unskid_pc", 128'(aDn.pc), 128'(32'h504));
    checkVal("unskid_occ", 128'(aOcc), 128'(1));
    checkVal("unskid_in_ready", 128'(aUp.ready), 128'(1));
    tick();
    checkVal("unskid_empty", 128'(aDn.valid), 128'(0));
    checkVal("unskid_stall", 128'(aStall), 128'(3));

    // Flush while in SKID with a competing input offered.
    aDn.ready = 1'b0;
    offerA(si[0], 32'h600);
    tick();
    offerA(si[1], 32'h604);
    tick();
    checkVal("fl_pre_occ", 128'(aOcc), 128'(2));
    flushA = 1'b1;
    aUp.valid = 1'b1;
    aUp.instr = 32'h1234_5678;
    #1;
    checkVal("fl_in_ready", 128'(aUp.ready), 128'(0));
    tick();
    flushA = 1'b0;
    aUp.valid = 1'b0;
    checkVal("fl_valid", 128'(aDn.valid), 128'(0));
    checkVal("fl_instr", 128'(aDn.instr), 128'(0));
    checkVal("fl_occ", 128'(aOcc), 128'(0));
    checkVal("fl_pc_hold", 128'(aDn.pc), 128'(32'h600));
    checkVal("fl_stall", 128'(aStall), 128'(5));
    aDn.ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkVal("fl_no_leak_valid", 128'(aDn.valid), 128'(0));
      checkVal("fl_no_leak_instr", 128'(aDn.instr), 128'(0));
    end

    // Asynchronous reset mid-cycle from SKID.
    aDn.ready = 1'b0;
    offerA(si[0], 32'h700);
    tick();
    offerA(si[1], 32'h704);
    tick();
    aUp.valid = 1'b0;
    checkVal("ar_pre_occ", 128'(aOcc), 128'(2));
    #3;
    rst = 1'b1;
    #1;
    checkVal("ar_valid", 128'(aDn.valid), 128'(0));
    checkVal("ar_instr", 128'(aDn.instr), 128'(0));
    checkVal("ar_pc", 128'(aDn.pc), 128'(32'h0000_3008));
    checkVal("ar_occ", 128'(aOcc), 128'(0));
    checkVal("ar_stall", 128'(aStall), 128'(0));
    checkVal("ar_in_ready", 128'(aUp.ready), 128'(0));
    tick();
    rst = 1'b0;
    #1;
    checkVal("ar_rel_in_ready", 128'(aUp.ready), 128'(1));

    // Stall counter saturation on the 4-bit instance.
    bDn.ready = 1'b0;
    bUp.valid = 1'b1;
    bUp.instr = 32'hCAFE_0001;
    bUp.pc    = 32'h10;
    tick();
    bUp.valid = 1'b0;
    checkVal("sat_valid", 128'(bDn.valid), 128'(1));
    repeat (20) tick();
    checkVal("sat_15", 128'(bStall), 128'(15));
    repeat (3) tick();
    checkVal("sat_hold", 128'(bStall), 128'(15));

    // Randomized traffic on the narrow instance against the FIFO model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    lastHead = '{instr: 32'h0, pc: 32'h0000_3008, data: 32'h0, aux: 5'h0};
    mStall = 0;
    for (int i = 0; i < 400; i++) begin
      bUp.valid = ($urandom_range(3) != 0);
      bUp.instr = $urandom;
      bUp.pc    = $urandom;
      bUp.data  = $urandom;
      bUp.aux   = 5'($urandom);
      bDn.ready = ($urandom_range(2) != 0);
      flushB    = ($urandom_range(31) == 0);
      @(negedge clk);
      expValid = (mq.size() > 0);
      head     = expValid ? mq[0] : lastHead;
      expReady = (mq.size() < 2) && !flushB;
      checkVal("b_valid", 128'(bDn.valid), 128'(expValid));
      checkVal("b_instr", 128'(bDn.instr), 128'(expValid ? head.instr : 32'h0));
      checkVal("b_pc", 128'(bDn.pc), 128'(head.pc));
      checkVal("b_data", 128'(bDn.data), 128'(head.data));
      checkVal("b_aux", 128'(bDn.aux), 128'(head.aux));
      checkVal("b_in_ready", 128'(bUp.ready), 128'(expReady));
      checkVal("b_occ", 128'(bOcc), 128'(mq.size()));
      checkVal("b_stall", 128'(bStall), 128'(mStall));
      mInFire   = bUp.valid && expReady;
      mOutFire  = expValid && bDn.ready;
      mStallInc = expValid && !bDn.ready;
      mFlush    = flushB;
      newEnt    = '{instr: bUp.instr, pc: bUp.pc, data: bUp.data, aux: bUp.aux};
      @(posedge clk);
      #1;
      if (mStallInc && mStall < 15) mStall++;
      if (mFlush) begin
        mq.delete();
      end else begin
        if (mOutFire) void'(mq.pop_front());
        if (mInFire) mq.push_back(newEnt);
      end
      if (mq.size() > 0) lastHead = mq[0];
    end
    flushB = 1'b0;

    $display("[TB] %0d tests run, %0d failed", numTests, numFail);
    $finish;
  end

endmodule
